proc_launch_ctrl: RTL and testbench

PROC_LAUNCH_CTRL -- requirements
Module: proc_launch_ctrl

---
 rtl/proc_launch_ctrl.sv | 129 ++++++++++++
 tb/tb_proc_launch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_launch_ctrl.sv
// Launch sequencer for multi_core_processor: load data memory, pulse the
// processor reset, run until end_process or timeout, and report results.
module proc_launch_ctrl #(
    parameter int          CNT_W    = 16,
    parameter int unsigned TIMEOUT  = 16'd50000,
    parameter int          PRST_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             load_req,
    input  logic             load_done,
    output logic             proc_rst,
    output logic             status,
    input  logic             end_process,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [7:0]       run_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRST,
        RUN,
        DONE,
        ERR
    } state_t;

    localparam int              PW        = (PRST_CYC > 1) ? $clog2(PRST_CYC) : 1;
    localparam logic [PW-1:0]   PRST_LAST = PW'(PRST_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [PW-1:0]    prst_cnt_q, prst_cnt_d;
    logic             load_req_q, load_req_d;
    logic             proc_rst_q, proc_rst_d;
    logic             status_q, status_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [7:0]       run_count_q, run_count_d;

    always_comb begin
        state_d       = state_q;
        prst_cnt_d    = '0;
        cycle_count_d = cycle_count_q;
        run_count_d   = run_count_q;

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (load_done) state_d = PRST;
            end
            PRST: begin
                if (prst_cnt_q == PRST_LAST) state_d = RUN;
                else                         prst_cnt_d = prst_cnt_q + 1'b1;
            end
            RUN: begin
                // The cycle that sees end_process or the timeout still counts as a RUN cycle
                if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + 1'b1;
                if (end_process)                    state_d = DONE;
                else if (cycle_count_q == RUN_LAST) state_d = ERR;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                if (start) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != RUN && state_d == RUN) cycle_count_d = '0;
        if (state_q == RUN && state_d == DONE) run_count_d = run_count_q + 8'd1;

        // Every flag is registered from the state being entered
        load_req_d = (state_d == LOAD);
        proc_rst_d = !(state_d == PRST || state_d == ERR);
        status_d   = (state_d == RUN);
        busy_d     = (state_d == LOAD || state_d == PRST || state_d == RUN);
        done_d     = (state_d == DONE);
        timeout_d  = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            prst_cnt_q    <= '0;
            load_req_q    <= 1'b0;
            proc_rst_q    <= 1'b0;
            status_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            run_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            prst_cnt_q    <= prst_cnt_d;
            load_req_q    <= load_req_d;
            proc_rst_q    <= proc_rst_d;
            status_q      <= status_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
            run_count_q   <= run_count_d;
        end
    end

    assign load_req    = load_req_q;
    assign proc_rst    = proc_rst_q;
    assign status      = status_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign run_count   = run_count_q;

endmodule

// File: tb/tb_proc_launch_ctrl.sv
// Bench for proc_launch_ctrl: one instance with the default timeout and one
// with TIMEOUT=20, driven by directed and randomized launches.
module tb_proc_launch_ctrl;

    localparam int CNT_W    = 16;
    localparam int PRST_CYC = 2;
    localparam int TIMEOUT0 = 50000;
    localparam int TIMEOUT1 = 20;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start;
    logic [1:0] loadDone;
    logic [1:0] endProcess;
    logic [1:0] loadReq;
    logic [1:0] procRst;
    logic [1:0] status;
    logic [1:0] busy;
    logic [1:0] done;
    logic [1:0] timeoutFlag;
    logic [1:0][CNT_W-1:0] cycleCount;
    logic [1:0][7:0]       runCount;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: values the held counters should show for each instance
    int expCycle [2];
    int expRun   [2];

    always #5 clk = ~clk;

    proc_launch_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT0), .PRST_CYC(PRST_CYC)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .load_req(loadReq[0]),
        .load_done(loadDone[0]), .proc_rst(procRst[0]), .status(status[0]),
        .end_process(endProcess[0]), .busy(busy[0]), .done(done[0]),
        .timeout(timeoutFlag[0]), .cycle_count(cycleCount[0]), .run_count(runCount[0])
    );

    proc_launch_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT1), .PRST_CYC(PRST_CYC)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .load_req(loadReq[1]),
        .load_done(loadDone[1]), .proc_rst(procRst[1]), .status(status[1]),
        .end_process(endProcess[1]), .busy(busy[1]), .done(done[1]),
        .timeout(timeoutFlag[1]), .cycle_count(cycleCount[1]), .run_count(runCount[1])
    );

    function automatic int timeoutOf(input int u);
        return (u == 0) ? TIMEOUT0 : TIMEOUT1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input int u, input string phase, input bit eLoadReq,
                            input bit eProcRst, input bit eStatus, input bit eBusy,
                            input bit eDone, input bit eTimeout);
        checkOutput($sformatf("u%0d %s load_req", u, phase), 32'(loadReq[u]), 32'(eLoadReq));
        checkOutput($sformatf("u%0d %s proc_rst", u, phase), 32'(procRst[u]), 32'(eProcRst));
        checkOutput($sformatf("u%0d %s status", u, phase), 32'(status[u]), 32'(eStatus));
        checkOutput($sformatf("u%0d %s busy", u, phase), 32'(busy[u]), 32'(eBusy));
        checkOutput($sformatf("u%0d %s done", u, phase), 32'(done[u]), 32'(eDone));
        checkOutput($sformatf("u%0d %s timeout", u, phase), 32'(timeoutFlag[u]), 32'(eTimeout));
        checkOutput($sformatf("u%0d %s cycle_count", u, phase), 32'(cycleCount[u]),
                    32'(expCycle[u]));
        checkOutput($sformatf("u%0d %s run_count", u, phase), 32'(runCount[u]),
                    32'(expRun[u]));
    endtask

    // One full launch from IDLE. runLen is the RUN cycle on which end_process
    // is raised; 0 means never. Irrelevant inputs are randomly toggled.
    task automatic applyStimulus(input int u, input int loadDelay, input int runLen);
        int  t;
        bit  finishes;
        t        = timeoutOf(u);
        finishes = (runLen >= 1) && (runLen <= t);

        start[u] = 1'b1;
        step();
        start[u] = 1'b0;
        checkAll(u, "load", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < loadDelay; i++) begin
            start[u]      = 1'($urandom_range(0, 1));
            endProcess[u] = 1'($urandom_range(0, 1));
            step();
            checkAll(u, "load_wait", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        start[u]      = 1'b0;
        endProcess[u] = 1'b0;
        loadDone[u]   = 1'b1;
        step();
        loadDone[u] = 1'b0;
        checkAll(u, "prst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < PRST_CYC; k++) begin
            start[u]      = 1'($urandom_range(0, 1));
            loadDone[u]   = 1'($urandom_range(0, 1));
            endProcess[u] = 1'($urandom_range(0, 1));
            step();
            checkAll(u, "prst_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        start[u]      = 1'b0;
        loadDone[u]   = 1'b0;
        endProcess[u] = 1'b0;
        step();
        expCycle[u] = 0;
        checkAll(u, "run_entry", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int n = 1; n <= t; n++) begin
            start[u]      = 1'($urandom_range(0, 1));
            loadDone[u]   = 1'($urandom_range(0, 1));
            endProcess[u] = (n == runLen);
            step();
            expCycle[u] = n;
            if (n == runLen) begin
                expRun[u] = (expRun[u] + 1) % 256;
                checkAll(u, "done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                break;
            end else if (n == t) begin
                checkAll(u, "err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                break;
            end else begin
                checkAll(u, "run", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            end
        end
        start[u]      = 1'b0;
        loadDone[u]   = 1'b0;
        endProcess[u] = 1'b0;

        if (finishes) begin
            step();
            checkAll(u, "idle_after_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            loadDone[u]   = 1'b1;
            endProcess[u] = 1'b1;
            step();
            loadDone[u]   = 1'b0;
            endProcess[u] = 1'b0;
            checkAll(u, "err_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            start[u] = 1'b1;
            step();
            start[u] = 1'b0;
            checkAll(u, "err_clear", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            checkAll(u, "idle_after_err", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = '0;
        loadDone   = '0;
        endProcess = '0;
        for (int u = 0; u < 2; u++) begin
            expCycle[u] = 0;
            expRun[u]   = 0;
        end
        #1 rst = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) checkAll(u, "reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        for (int u = 0; u < 2; u++) checkAll(u, "reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int u = 0; u < 2; u++) checkAll(u, "first_cycle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Spurious loader and processor pulses while idle
        loadDone   = 2'b11;
        endProcess = 2'b11;
        step();
        loadDone   = '0;
        endProcess = '0;
        for (int u = 0; u < 2; u++) checkAll(u, "idle_spurious", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal launch, then timeout, collision and randomized launches
        applyStimulus(0, 5, 100);
        applyStimulus(1, int'($urandom_range(1, 8)), 0);
        applyStimulus(1, 3, TIMEOUT1);
        applyStimulus(1, 2, TIMEOUT1 - 1);
        for (int r = 0; r < 12; r++)
            applyStimulus(1, int'($urandom_range(1, 6)), int'($urandom_range(0, TIMEOUT1 + 6)));
        for (int r = 0; r < 4; r++)
            applyStimulus(0, int'($urandom_range(1, 6)), int'($urandom_range(1, 60)));

        // Asynchronous reset landing between clock edges in the middle of RUN
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        loadDone[0] = 1'b1;
        step();
        loadDone[0] = 1'b0;
        repeat (PRST_CYC + 7) step();
        checkOutput("u0 pre_reset status", 32'(status[0]), 32'd1);
        #3 rst = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            expCycle[u] = 0;
            expRun[u]   = 0;
            checkAll(u, "async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        #2 rst = 1'b1;
        step();
        for (int u = 0; u < 2; u++) checkAll(u, "post_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 256 back-to-back launches must bring run_count round to zero
        for (int r = 0; r < 256; r++)
            applyStimulus(0, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        checkOutput("u0 wrap run_count", 32'(runCount[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
